// File: rtl/hc_pkg.sv
// Shared Hamming(7,4) definitions: widths, codeword type, encoder FSM states
// and the reference encode function used by both encoder and decoder benches.
package hc_pkg;

    localparam int DATA_WD = 4;
    localparam int CHK_WD  = 3;
    localparam int CW_WD   = 7;

    typedef logic [CW_WD:1] cw_t;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    // Data sits at positions 3,5,6,7; check bit k covers positions with bit k set.
    function automatic cw_t hc_encode(input logic [DATA_WD-1:0] nib);
        cw_t cw;
        cw[3] = nib[0];
        cw[5] = nib[1];
        cw[6] = nib[2];
        cw[7] = nib[3];
        cw[1] = cw[3] ^ cw[5] ^ cw[7];
        cw[2] = cw[3] ^ cw[6] ^ cw[7];
        cw[4] = cw[5] ^ cw[6] ^ cw[7];
        return cw;
    endfunction

endpackage

// File: rtl/hc_enc_core.sv
// Combinational Hamming(7,4) encoder: one nibble in, one codeword (positions 1..7) out.
module hc_enc_core (
    input  logic [hc_pkg::DATA_WD-1:0] i_nib,
    output hc_pkg::cw_t                o_cw
);
    import hc_pkg::*;

    assign o_cw = hc_encode(i_nib);

endmodule

// File: rtl/hc_enc_stream.sv
// Streaming Hamming(7,4) encoder: bytes in, one registered codeword per nibble out, low nibble first.
// Optional build macro HC_ERR_INJ_EN adds i_inj_pos to flip one bit of each loaded codeword.
module hc_enc_stream #(
    parameter int DATA_WD = 4,
    parameter int CHK_WD  = 3,
    parameter int BYTE_WD = 8,
    parameter int CNT_WD  = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_in_ready,
    input  logic [BYTE_WD-1:0]         i_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [DATA_WD+CHK_WD:1]    o_enc_data,
    output logic                       o_last,
    output logic [CNT_WD-1:0]          o_cw_cnt
`ifdef HC_ERR_INJ_EN
    ,
    input  logic [CHK_WD-1:0]          i_inj_pos
`endif
);
    import hc_pkg::*;

    localparam int NIB    = BYTE_WD / DATA_WD;
    localparam int IDX_WD = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_WD-1:0] IDX_LAST = IDX_WD'(NIB - 1);

    state_t               state, state_nxt;
    logic [BYTE_WD-1:0]   byte_q;
    logic [IDX_WD-1:0]    idx, idx_nxt;
    logic                 xfer, load, advance;
    logic [DATA_WD-1:0]   nib_sel;
    cw_t                  cw_enc, cw_ld;

    assign o_valid    = (state == S_SEND);
    assign o_last     = o_valid && (idx == IDX_LAST);
    assign o_in_ready = !o_valid || (o_last && i_ready);

    assign xfer    = o_valid && i_ready;
    assign load    = i_valid && o_in_ready;
    assign advance = xfer && !o_last;
    assign idx_nxt = idx + 1'b1;

    // A fresh byte always starts from its low nibble; otherwise step to the next held nibble.
    assign nib_sel = load ? i_data[DATA_WD-1:0]
                          : byte_q[int'(idx_nxt)*DATA_WD +: DATA_WD];

    hc_enc_core u_core (
        .i_nib (nib_sel),
        .o_cw  (cw_enc)
    );

`ifdef HC_ERR_INJ_EN
    always_comb begin
        cw_ld = cw_enc;
        for (int k = 1; k <= CW_WD; k++) begin
            if (i_inj_pos == CHK_WD'(k)) cw_ld[k] = ~cw_enc[k];
        end
    end
`else
    assign cw_ld = cw_enc;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (load) state_nxt = S_SEND;
            S_SEND: if (xfer && o_last && !load) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output register: loads on acceptance or advance, holds while stalled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx        <= '0;
            o_enc_data <= '0;
            o_cw_cnt   <= '0;
        end else begin
            if (load) begin
                byte_q     <= i_data;
                idx        <= '0;
                o_enc_data <= cw_ld;
            end else if (advance) begin
                idx        <= idx_nxt;
                o_enc_data <= cw_ld;
            end
            if (xfer && !(&o_cw_cnt)) o_cw_cnt <= o_cw_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hc_enc_stream.sv
// Scoreboard bench for hc_enc_stream: directed byte vectors plus a full byte sweep with random backpressure.
module tb_hc_enc_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:1]  enc_data;
    logic        last;
    logic [15:0] cw_cnt;
    logic [2:0]  inj_pos;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [6:0] cw;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

`ifdef HC_ERR_INJ_EN
    localparam int INJ_N = 2;
`else
    localparam int INJ_N = 0;
`endif

    always #5 clk = ~clk;

    hc_enc_stream dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (in_valid),
        .o_in_ready (in_ready),
        .i_data     (in_data),
        .o_valid    (out_valid),
        .i_ready    (out_ready),
        .o_enc_data (enc_data),
        .o_last     (last),
        .o_cw_cnt   (cw_cnt)
`ifdef HC_ERR_INJ_EN
        ,
        .i_inj_pos  (inj_pos)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic push(input logic [6:0] cw, input logic lst);
        exp_t e;
        e.cw   = cw;
        e.last = lst;
        exp_q.push_back(e);
    endtask

    // Independent model: generic Hamming rule, check bit k = parity of all positions with bit k set.
    function automatic logic [6:0] model_cw(input logic [3:0] d);
        logic [7:1] v;
        logic       p;
        v    = '0;
        v[3] = d[0];
        v[5] = d[1];
        v[6] = d[2];
        v[7] = d[3];
        for (int k = 1; k < 8; k = k * 2) begin
            p = 1'b0;
            for (int q = 1; q < 8; q++) begin
                if ((q & k) != 0 && q != k) p = p ^ v[q];
            end
            v[k] = p;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer is popped and compared against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cw", {25'd0, enc_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("mon_cw", {25'd0, enc_data}, {25'd0, e.cw});
                check("mon_last", {31'd0, last}, {31'd0, e.last});
            end
        end
    end

    initial begin
        int guard;
        logic acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        inj_pos   = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", {31'd0, out_valid}, 0);
        check("rst_data", {25'd0, enc_data}, 0);
        check("rst_last", {31'd0, last}, 0);
        check("rst_cnt", {16'd0, cw_cnt}, 0);
        check("rst_in_ready", {31'd0, in_ready}, 1);

        // Single byte 0xFB
        in_valid = 1'b1;
        in_data  = 8'hFB;
        push(7'h55, 1'b0);
        push(7'h7F, 1'b1);
        tick();
        in_valid = 1'b0;
        check("fb_c1_valid", {31'd0, out_valid}, 1);
        check("fb_c1_data", {25'd0, enc_data}, 32'h55);
        check("fb_c1_last", {31'd0, last}, 0);
        tick();
        check("fb_c2_data", {25'd0, enc_data}, 32'h7F);
        check("fb_c2_last", {31'd0, last}, 1);
        tick();
        check("fb_c3_valid", {31'd0, out_valid}, 0);
        check("fb_c3_cnt", {16'd0, cw_cnt}, 2);

        // Back-to-back 0x10, 0x01
        in_valid = 1'b1;
        in_data  = 8'h10;
        push(7'h00, 1'b0);
        push(7'h07, 1'b1);
        push(7'h07, 1'b0);
        push(7'h00, 1'b1);
        tick();
        in_data = 8'h01;
        check("b2b_busy_ready", {31'd0, in_ready}, 0);
        check("b2b_cw0", {25'd0, enc_data}, 32'h00);
        tick();
        check("b2b_last_ready", {31'd0, in_ready}, 1);
        check("b2b_cw1", {25'd0, enc_data}, 32'h07);
        tick();
        in_valid = 1'b0;
        check("b2b_nobubble", {31'd0, out_valid}, 1);
        check("b2b_cw2", {25'd0, enc_data}, 32'h07);
        tick();
        check("b2b_cw3", {25'd0, enc_data}, 32'h00);
        check("b2b_cw3_last", {31'd0, last}, 1);
        tick();
        check("b2b_idle", {31'd0, out_valid}, 0);
        check("b2b_cnt", {16'd0, cw_cnt}, 6);

        // Stall on byte 0xB0
        in_valid  = 1'b1;
        in_data   = 8'hB0;
        out_ready = 1'b0;
        push(7'h00, 1'b0);
        push(7'h55, 1'b1);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_data", {25'd0, enc_data}, 32'h00);
            check("stall_in_ready", {31'd0, in_ready}, 0);
            check("stall_valid", {31'd0, out_valid}, 1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("stall_cw1", {25'd0, enc_data}, 32'h55);
        tick();
        check("stall_cnt", {16'd0, cw_cnt}, 8);

        // Reset while the high nibble of 0xFB is still pending
        in_valid = 1'b1;
        in_data  = 8'hFB;
        push(7'h55, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        check("mrst_valid", {31'd0, out_valid}, 0);
        check("mrst_cnt", {16'd0, cw_cnt}, 0);
        tick();
        tick();
        check("mrst_no_emit", {31'd0, out_valid}, 0);
        check("mrst_queue", exp_q.size(), 0);

`ifdef HC_ERR_INJ_EN
        inj_pos  = 3'd5;
        in_valid = 1'b1;
        in_data  = 8'h0B;
        push(7'h45, 1'b0);
        push(7'h10, 1'b1);
        tick();
        in_valid = 1'b0;
        check("inj_cw0", {25'd0, enc_data}, 32'h45);
        tick();
        tick();
        inj_pos = '0;
`endif

        // All bytes with random backpressure
        for (int b = 0; b < 256; b++) begin
            in_valid = 1'b1;
            in_data  = 8'(b);
            push(model_cw(in_data[3:0]), 1'b0);
            push(model_cw(in_data[7:4]), 1'b1);
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 100) begin
                out_ready = 1'($urandom_range(0, 1));
                #1;
                acc = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) check("sweep_accept_timeout", 0, 1);
        end
        in_valid = 1'b0;
        guard    = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            out_ready = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        out_ready = 1'b1;
        tick();
        tick();
        check("sweep_drained", exp_q.size(), 0);
        check("sweep_cnt", {16'd0, cw_cnt}, 512 + INJ_N);
        check("sweep_idle", {31'd0, out_valid}, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hc_enc_stream.md
Name: hc_enc_stream

Overview:
- Streaming Hamming(7,4) encoder; directly upstream of the Hamming decoder (hc_dec).
- Accepts bytes over a valid/ready handshake.
- Splits each byte into nibbles, low nibble first.
- Emits one registered 7-bit codeword per nibble on a valid/ready output, with bit layout identical to what hc_dec consumes.

Parameters:
- DATA_WD, 4, data bits per codeword. Fixed at 4; other values are unsupported.
- CHK_WD, 3, check bits per codeword. Fixed at 3.
- BYTE_WD, 8, input word width. Must be a multiple of DATA_WD; NIB = BYTE_WD/DATA_WD.
- CNT_WD, 16, width of the codeword counter.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  input byte valid.
- o_in_ready  out  1  input byte accepted when i_valid & o_in_ready.
- i_data  in  BYTE_WD  input byte.
- o_valid  out  1  codeword valid.
- i_ready  in  1  downstream ready; transfer when o_valid & i_ready.
- o_enc_data  out  [DATA_WD+CHK_WD:1]  codeword, positions 1..7.
- o_last  out  1  current codeword carries the top nibble of its byte.
- o_cw_cnt  out  CNT_WD  count of codewords transferred, saturating.

Behaviour:
- Reset values: o_valid=0, o_enc_data=0, o_last=0, o_cw_cnt=0, nibble index=0, state=S_IDLE. Reset mid-operation discards any held byte and codeword without emitting it.
- Codeword layout, nibble d[4:1]:
  - c3=d1, c5=d2, c6=d3, c7=d4.
  - c1=c3^c5^c7, c2=c3^c6^c7, c4=c5^c6^c7.
- States:
  - S_IDLE: no byte held; o_valid=0.
  - S_SEND: byte held in byte_q; o_valid=1; o_enc_data = enc(nibble[idx]).
- o_in_ready = !o_valid | (o_last & i_ready). Combinational; no path from i_valid.
- S_IDLE & i_valid:
  - byte_q<=i_data, idx<=0, o_enc_data<=enc(i_data[DATA_WD-1:0]).
  - Go to S_SEND. Latency: one cycle from acceptance to o_valid.
- S_SEND & i_ready & idx<NIB-1: idx<=idx+1, o_enc_data<=enc(next nibble).
- S_SEND & i_ready & o_last:
  - If i_valid: load the new byte as above and stay in S_SEND, giving back-to-back codewords with no bubble.
  - Otherwise go to S_IDLE and clear o_valid.
- S_SEND & !i_ready: o_enc_data, o_last and idx hold stable. This is the AXI-style rule: valid is never withdrawn.
- o_last = o_valid & (idx==NIB-1).
- o_cw_cnt increments on every output transfer and saturates at all-ones; it never wraps.
- Sustained throughput is one codeword per cycle when i_ready=1.
- A new byte is accepted at most once per NIB cycles.

Optional Feature:
- Macro: HC_ERR_INJ_EN.
- When defined:
  - Adds input i_inj_pos, width CHK_WD, sampled whenever a codeword is loaded into the output register.
  - Value k in 1..7 XORs bit k of the loaded codeword; value 0 injects nothing.
  - Used to exercise the single-bit correction in hc_dec.
- When undefined: the port is absent and codewords are always clean.

Decomposition:
- Package hc_pkg:
  - Constants DATA_WD=4, CHK_WD=3, CW_WD=7.
  - Typedef cw_t (logic [CW_WD:1]).
  - State enum {S_IDLE, S_SEND}.
  - Function hc_encode(nibble) returning cw_t, shared with decoder benches.
- Sub-module hc_enc_core: purely combinational, 4-bit nibble in, 7-bit codeword out. Instantiated once, driven by a mux that selects the nibble being loaded.

Test Plan:
- Reset, then single byte 0xFB with i_ready=1: accepted at cycle 0.
  - Cycle 1: o_enc_data=7'h55, o_last=0.
  - Cycle 2: 7'h7F, o_last=1.
  - Cycle 3: o_valid=0; o_cw_cnt=2.
- Bytes 0x10, 0x01 back-to-back with i_ready=1: codewords 7'h00, 7'h07, 7'h07, 7'h00 on 4 consecutive cycles with no bubble. o_in_ready is high on the cycle the first byte's last codeword transfers.
- Byte 0xB0 with i_ready held low for 3 cycles: o_enc_data stays 7'h00 and o_in_ready stays 0. Then i_ready=1 gives 7'h00 followed by 7'h55.
- Assert i_rst while holding byte 0xFB after the first codeword transfers: next cycle o_valid=0 and o_cw_cnt=0. No 7'h7F is emitted.
- All 256 bytes through hc_enc_stream into hc_dec, with random i_ready: every decoded nibble pair reconstructs its byte, and o_err_flag=0 throughout.
- With HC_ERR_INJ_EN, i_inj_pos=5, byte 0x0B:
  - First codeword is 7'h45.
  - hc_dec outputs 4'hB with o_err_flag=1.
